// File: rtl/sar_search.sv
// sar_search: successive-approximation search that recovers an unknown value
// from a magnitude comparator's greater/less/equal flags, one bit per cycle.
`default_nettype none

module sar_search #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             agb,
    input  logic             alb,
    input  logic             aeb,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [KW-1:0]    k, k_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] probe_n, result_n;
    logic             busy_n, done_n, err_n;
    logic [WIDTH-1:0] bit_k;
    logic             onehot;

    assign bit_k  = WIDTH'(1) << k;
    assign onehot = (agb & ~alb & ~aeb) | (~agb & alb & ~aeb) | (~agb & ~alb & aeb);

    always_comb begin
        state_n  = state;
        k_n      = k;
        acc_n    = acc;
        probe_n  = probe;
        result_n = result;
        err_n    = err;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                probe_n = '0;
                if (start) begin
                    acc_n   = '0;
                    k_n     = KW'(WIDTH - 1);
                    probe_n = WIDTH'(1) << (WIDTH - 1);
                    err_n   = 1'b0;
                    state_n = PROBE;
                end
            end
            PROBE: begin
                if (!onehot) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    done_n   = 1'b1;
                    probe_n  = '0;
                    state_n  = IDLE;
                end else if (aeb) begin
                    result_n = probe;
                    done_n   = 1'b1;
                    probe_n  = '0;
                    state_n  = IDLE;
                end else begin
                    // agb keeps the trial bit, alb drops it
                    acc_n = agb ? probe : (probe & ~bit_k);
                    if (k != '0) begin
                        k_n     = k - KW'(1);
                        probe_n = acc_n | (bit_k >> 1);
                    end else begin
                        result_n = acc_n;
                        done_n   = 1'b1;
                        probe_n  = '0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                probe_n = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == PROBE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= KW'(WIDTH - 1);
            acc    <= '0;
            probe  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            acc    <= acc_n;
            probe  <= probe_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// tb_sar_search: scoreboard bench for sar_search at WIDTH=2 and WIDTH=4 with
// behavioural comparator models.
`default_nettype none

module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start2 = 1'b0, start4 = 1'b0;
    int         a2 = 0, a4 = 0;
    logic       bad2 = 1'b0, bad4 = 1'b0;
    logic       agb2, alb2, aeb2, agb4, alb4, aeb4;
    logic [1:0] probe2, result2;
    logic [3:0] probe4, result4;
    logic       busy2, done2, err2, busy4, done4, err4;

    int passed = 0;
    int total  = 0;
    int pq[$];
    int rq[$];

    always #5 clk = ~clk;

    // Combinational comparators; "bad" forces agb=alb=1 (not one-hot)
    assign agb2 = bad2 | (a2 > int'(probe2));
    assign alb2 = bad2 | (a2 < int'(probe2));
    assign aeb2 = ~bad2 & (a2 == int'(probe2));
    assign agb4 = bad4 | (a4 > int'(probe4));
    assign alb4 = bad4 | (a4 < int'(probe4));
    assign aeb4 = ~bad4 & (a4 == int'(probe4));

    sar_search #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .agb(agb2), .alb(alb2), .aeb(aeb2),
        .probe(probe2), .busy(busy2), .done(done2), .result(result2), .err(err2)
    );

    sar_search #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .agb(agb4), .alb(alb4), .aeb(aeb4),
        .probe(probe4), .busy(busy4), .done(done4), .result(result4), .err(err4)
    );

    // Interval-bisection reference: pushes expected probes and the final result
    task automatic model(input int w, input int a, input bit bad);
        int lo = 0;
        int hi = (1 << w) - 1;
        int p;
        if (bad) begin
            pq.push_back(1 << (w - 1));
            rq.push_back(0);
            return;
        end
        forever begin
            p = lo + (hi - lo + 1) / 2;
            pq.push_back(p);
            if (a == p) begin
                rq.push_back(p);
                return;
            end
            if (a > p) lo = p;
            else       hi = p - 1;
            if (lo == hi) begin
                rq.push_back(lo);
                return;
            end
        end
    endtask

    // Called at a sample point (#1 after a rising edge)
    task automatic run_search(input int w, input int a, input bit mid_start, input bit bad);
        int n = 0;
        bit got_done = 0;
        int exp_res;
        pq.delete();
        model(w, a, bad);
        if (w == 2) begin a2 = a; bad2 = bad; start2 = 1'b1; end
        else        begin a4 = a; bad4 = bad; start4 = 1'b1; end
        @(posedge clk); #1;
        start2 = 1'b0; start4 = 1'b0;
        total++;
        if (((w == 2) ? err2 : err4) !== 1'b0)
            $display("FAIL err_clear_on_start w=%0d: got 1 expected 0", w);
        else passed++;
        for (int c = 0; c < w + 2 && !got_done; c++) begin
            int  p  = (w == 2) ? int'(probe2)  : int'(probe4);
            int  r  = (w == 2) ? int'(result2) : int'(result4);
            bit  d  = (w == 2) ? done2 : done4;
            bit  b  = (w == 2) ? busy2 : busy4;
            bit  e  = (w == 2) ? err2  : err4;
            if (d) begin
                got_done = 1;
                exp_res = rq.pop_front();
                total++;
                if (r !== exp_res)
                    $display("FAIL result w=%0d a=%0d: got %0d expected %0d", w, a, r, exp_res);
                else passed++;
                total++;
                if (e !== bad)
                    $display("FAIL err w=%0d a=%0d: got %0d expected %0d", w, a, e, bad);
                else passed++;
                total++;
                if (b !== 1'b0 || p !== 0)
                    $display("FAIL idle_on_done w=%0d: got busy=%0d probe=%0d expected 0 0", w, b, p);
                else passed++;
            end else begin
                total++;
                if (pq.size() == 0)
                    $display("FAIL extra_probe w=%0d a=%0d: got probe %0d expected done", w, a, p);
                else if (b !== 1'b1 || p !== pq[0])
                    $display("FAIL probe w=%0d a=%0d: got probe=%0d busy=%0d expected probe=%0d busy=1",
                             w, a, p, b, pq[0]);
                else passed++;
                if (pq.size() != 0) void'(pq.pop_front());
                n++;
                if (mid_start && n == 2) begin
                    if (w == 2) start2 = 1'b1; else start4 = 1'b1;
                end
                @(posedge clk); #1;
                start2 = 1'b0; start4 = 1'b0;
            end
        end
        total++;
        if (!got_done)
            $display("FAIL timeout w=%0d a=%0d: got no done expected done within %0d cycles", w, a, w + 1);
        else if (pq.size() != 0 || n > w)
            $display("FAIL probe_count w=%0d a=%0d: got %0d probes expected %0d", w, a, n, n + pq.size());
        else passed++;
        bad2 = 1'b0; bad4 = 1'b0;
        rq.delete();
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({probe2, busy2, done2, result2, err2, probe4, busy4, done4, result4, err4} !== '0)
            $display("FAIL reset_state: got %0d/%0d/%0d/%0d/%0d expected all 0",
                     probe4, busy4, done4, result4, err4);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_w2_basic();
        run_search(2, 2, 0, 0);
        run_search(2, 0, 0, 0);
        run_search(2, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) run_search(2, a, 0, 0);
    endtask

    task automatic test_w4_search();
        run_search(4, 11, 1, 0);
        run_search(4, 15, 0, 0);
        run_search(4, 0, 0, 0);
    endtask

    task automatic test_error();
        run_search(2, 1, 0, 1);
        run_search(2, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        a4 = 11;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (probe4 !== 4'd12)
            $display("FAIL pre_reset_probe: got %0d expected 12", probe4);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({probe4, busy4, done4, err4, result4} !== '0)
            $display("FAIL async_reset: got probe=%0d busy=%0d done=%0d err=%0d result=%0d expected all 0",
                     probe4, busy4, done4, err4, result4);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        run_search(4, 5, 0, 0);
    endtask

    initial begin
        test_reset();
        test_w2_basic();
        test_back_to_back();
        test_w4_search();
        test_error();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
